// File: rtl/multi_source_input_decoder_if.sv
// Bundles the controller-side inputs and game-side outputs of the input decoder.
// The master drives source buttons and selection controls; the slave is the decoder.
interface multi_source_input_decoder_if #(
  parameter int unsigned NumSrc = 3,
  parameter int unsigned NumBtn = 4
);
  localparam int unsigned SelW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  logic [SelW-1:0]          choice;
  logic                     auto_en;
  logic [NumSrc*NumBtn-1:0] src_btn;
  logic [NumSrc-1:0]        src_readable;
  logic [NumBtn-1:0]        btn;
  logic [NumBtn-1:0]        press;
  logic [NumBtn-1:0]        rel;  // release pulse; "release" is a reserved word
  logic [SelW-1:0]          active_src;
  logic                     src_switched;

  modport master (
    output choice, auto_en, src_btn, src_readable,
    input  btn, press, rel, active_src, src_switched
  );

  modport slave (
    input  choice, auto_en, src_btn, src_readable,
    output btn, press, rel, active_src, src_switched
  );
endinterface

// File: rtl/multi_source_input_decoder.sv
// Selects one of several controller sources (manually or by activity), debounces its
// buttons and emits levels plus press/release pulses with typematic auto-repeat.
module multi_source_input_decoder #(
  parameter int unsigned NumSrc    = 3,
  parameter int unsigned NumBtn    = 4,
  parameter int unsigned DebCyc    = 4,
  parameter int unsigned RepDelay  = 20,
  parameter int unsigned RepPeriod = 5,
  parameter int unsigned IdleCyc   = 8
) (
  input logic                         clk,
  input logic                         rst_n,
  multi_source_input_decoder_if.slave bus
);
  localparam int unsigned SelW   = (NumSrc > 1) ? $clog2(NumSrc) : 1;
  localparam int unsigned CntW   = $clog2(DebCyc + 1);
  localparam int unsigned RepMax = RepDelay + RepPeriod;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam int unsigned IdleW  = $clog2(IdleCyc + 1);

  typedef enum logic [0:0] {StHold, StScan} state_e;

  logic [NumSrc*NumBtn-1:0]      src_btn_q;
  logic [NumSrc-1:0]             rdy_q;
  logic [SelW-1:0]               active_q, new_src, target, cand;
  logic [NumBtn-1:0]             btn_q, btn_d, press_q, press_d, rel_q, rel_d, raw;
  logic [NumBtn-1:0][CntW-1:0]   cnt_q, cnt_d;
  logic [NumBtn-1:0][RepW-1:0]   rep_q, rep_d;
  logic [IdleW-1:0]              idle_q, idle_d;
  state_e                        state_q, state_d;
  logic                          sw_q, do_switch, cand_found, busy;
  logic [RepW-1:0]               rep_inc;

  always_comb begin
    raw = '0;
    if (rdy_q[active_q]) raw = src_btn_q[int'(active_q)*NumBtn +: NumBtn];
    busy = (raw != '0) || (btn_q != '0);

    if (32'(bus.choice) >= NumSrc) target = SelW'(NumSrc - 1);
    else                           target = bus.choice;

    cand_found = 1'b0;
    cand       = '0;
    for (int s = 0; s < int'(NumSrc); s++) begin
      if (!cand_found && s != int'(active_q) && rdy_q[s] &&
          src_btn_q[s*NumBtn +: NumBtn] != '0) begin
        cand_found = 1'b1;
        cand       = SelW'(s);
      end
    end
  end

  // Source selection: manual overrides the FSM and parks it in StHold.
  always_comb begin
    do_switch = 1'b0;
    new_src   = active_q;
    state_d   = state_q;
    idle_d    = idle_q;
    if (!bus.auto_en) begin
      state_d = StHold;
      idle_d  = '0;
      if (target != active_q) begin
        do_switch = 1'b1;
        new_src   = target;
      end
    end else begin
      unique case (state_q)
        StHold: begin
          if (busy)                          idle_d  = '0;
          else if (idle_q == IdleW'(IdleCyc)) state_d = StScan;
          else                               idle_d  = idle_q + 1'b1;
        end
        StScan: begin
          if (cand_found) begin
            do_switch = 1'b1;
            new_src   = cand;
            state_d   = StHold;
            idle_d    = '0;
          end else if (busy) begin
            state_d = StHold;
            idle_d  = '0;
          end
        end
        default: state_d = StHold;
      endcase
    end
  end

  always_comb begin
    btn_d   = btn_q;
    press_d = '0;
    rel_d   = '0;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    rep_inc = '0;
    if (do_switch) begin
      btn_d = '0;
      rel_d = btn_q;
      cnt_d = '0;
      rep_d = '0;
    end else begin
      for (int i = 0; i < int'(NumBtn); i++) begin
        if (raw[i] == btn_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntW'(DebCyc - 1)) begin
          cnt_d[i] = '0;
          btn_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end

        if (btn_d[i] && !btn_q[i]) begin
          press_d[i] = 1'b1;
          rep_d[i]   = '0;
        end else if (!btn_d[i] && btn_q[i]) begin
          rel_d[i] = 1'b1;
          rep_d[i] = '0;
        end else if (btn_q[i] && RepDelay != 0) begin
          // Counter reloads to RepDelay after each period pulse so it never wraps.
          rep_inc = rep_q[i] + 1'b1;
          if (rep_inc == RepW'(RepMax)) begin
            press_d[i] = 1'b1;
            rep_d[i]   = RepW'(RepDelay);
          end else begin
            press_d[i] = (rep_inc == RepW'(RepDelay));
            rep_d[i]   = rep_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_btn_q <= '0;
      rdy_q     <= '0;
      active_q  <= '0;
      btn_q     <= '0;
      press_q   <= '0;
      rel_q     <= '0;
      sw_q      <= 1'b0;
      cnt_q     <= '0;
      rep_q     <= '0;
      idle_q    <= '0;
      state_q   <= StHold;
    end else begin
      src_btn_q <= bus.src_btn;
      rdy_q     <= bus.src_readable;
      active_q  <= new_src;
      btn_q     <= btn_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      sw_q      <= do_switch;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      idle_q    <= idle_d;
      state_q   <= state_d;
    end
  end

  assign bus.btn          = btn_q;
  assign bus.press        = press_q;
  assign bus.rel          = rel_q;
  assign bus.active_src   = active_q;
  assign bus.src_switched = sw_q;
endmodule

// File: tb/tb_multi_source_input_decoder.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model of source selection, debounce and typematic repeat.
module tb_multi_source_input_decoder;
  localparam int NS   = 3;
  localparam int NB   = 4;
  localparam int DEB  = 4;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int IDLE = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multi_source_input_decoder_if #(.NumSrc(NS), .NumBtn(NB)) bus ();

  multi_source_input_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stimulus currently applied
  bit [11:0] cur_sb;
  bit [2:0]  cur_rd;
  bit [1:0]  cur_ch;
  bit        cur_ae;
  bit        cur_rst;

  // Reference model state
  bit [11:0] m_sb;
  bit [2:0]  m_rd;
  int        m_act;
  bit [3:0]  m_btn, m_press, m_rel;
  bit        m_sw;
  int        m_age[NB];
  int        m_held[NB];
  bit        m_scan;
  int        m_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [3:0] src_of(input bit [11:0] v, input int s);
    return v[s*NB +: NB];
  endfunction

  task automatic model_reset();
    m_sb = '0; m_rd = '0; m_act = 0; m_btn = '0; m_press = '0; m_rel = '0;
    m_sw = 1'b0; m_scan = 1'b0; m_idle = 0;
    for (int i = 0; i < NB; i++) begin m_age[i] = 0; m_held[i] = 0; end
  endtask

  task automatic model_step();
    bit [3:0] raw;
    bit       sw;
    int       nsrc;
    bit       busy;
    bit       nb;
    if (!cur_rst) begin
      model_reset();
      return;
    end
    raw   = m_rd[m_act] ? src_of(m_sb, m_act) : 4'b0;
    busy  = (raw != 0) || (m_btn != 0);
    sw    = 1'b0;
    nsrc  = m_act;
    if (!cur_ae) begin
      m_scan = 1'b0;
      m_idle = 0;
      nsrc   = (int'(cur_ch) >= NS) ? NS - 1 : int'(cur_ch);
      sw     = (nsrc != m_act);
    end else if (!m_scan) begin
      if (busy)               m_idle = 0;
      else if (m_idle == IDLE) m_scan = 1'b1;
      else                    m_idle++;
    end else begin
      for (int s = NS - 1; s >= 0; s--)
        if (s != m_act && m_rd[s] && src_of(m_sb, s) != 0) begin sw = 1'b1; nsrc = s; end
      if (sw || busy) begin m_scan = 1'b0; m_idle = 0; end
    end

    m_press = '0;
    m_rel   = '0;
    if (sw) begin
      m_rel = m_btn;
      m_btn = '0;
      m_act = nsrc;
      for (int i = 0; i < NB; i++) begin m_age[i] = 0; m_held[i] = 0; end
    end else begin
      for (int i = 0; i < NB; i++) begin
        nb = m_btn[i];
        if (raw[i] == m_btn[i]) m_age[i] = 0;
        else begin
          m_age[i]++;
          if (m_age[i] == DEB) begin nb = raw[i]; m_age[i] = 0; end
        end
        if (nb && !m_btn[i]) begin m_press[i] = 1'b1; m_held[i] = 0; end
        else if (!nb && m_btn[i]) begin m_rel[i] = 1'b1; m_held[i] = 0; end
        else if (nb) begin
          m_held[i]++;
          if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0))
            m_press[i] = 1'b1;
        end
        m_btn[i] = nb;
      end
    end
    m_sw = sw;
    m_sb = cur_sb;
    m_rd = cur_rd;
  endtask

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      rst_n            = cur_rst;
      bus.src_btn      = cur_sb;
      bus.src_readable = cur_rd;
      bus.choice       = cur_ch;
      bus.auto_en      = cur_ae;
      @(posedge clk);
      model_step();
      #1;
      chk("btn",      32'(bus.btn),          32'(m_btn));
      chk("press",    32'(bus.press),        32'(m_press));
      chk("release",  32'(bus.rel),          32'(m_rel));
      chk("active",   32'(bus.active_src),   32'(m_act));
      chk("switched", 32'(bus.src_switched), 32'(m_sw));
    end
  endtask

  initial begin
    model_reset();
    cur_rst = 1'b0; cur_sb = '1; cur_rd = 3'b111; cur_ch = 0; cur_ae = 1'b0;
    tick(2);
    chk("rst_active", 32'(bus.active_src), 0);
    chk("rst_btn", 32'(bus.btn), 0);
    cur_rst = 1'b1; cur_sb = '0;
    tick(3);

    // Debounce and glitch rejection
    cur_sb = 12'h001; tick(10);
    chk("deb_up", 32'(bus.btn), 1);
    cur_sb = 12'h000; tick(10);
    cur_sb = 12'h001; tick(3);
    cur_sb = 12'h000; tick(8);
    chk("glitch", 32'(bus.btn), 0);

    // Typematic repeat on Right
    cur_sb = 12'h008; tick(60);
    cur_sb = 12'h000; tick(10);

    // Manual switch with held button, out-of-range choice clamps
    cur_sb = 12'h001; tick(8);
    cur_ch = 2; tick(1);
    chk("man_sw", 32'(bus.src_switched), 1);
    chk("man_rel", 32'(bus.rel), 1);
    cur_ch = 3; tick(3);
    chk("clamp", 32'(bus.active_src), 2);
    cur_ch = 0; cur_sb = 12'h000; tick(5);

    // Auto selection
    cur_ae = 1'b1; tick(12);
    cur_sb = 12'h400; tick(3);
    chk("auto2", 32'(bus.active_src), 2);
    tick(10);
    cur_sb = 12'h410; tick(15);
    chk("auto_hold", 32'(bus.active_src), 2);
    cur_sb = 12'h010; tick(25);
    chk("auto1", 32'(bus.active_src), 1);
    cur_sb = 12'h000; cur_ae = 1'b0; cur_ch = 0; tick(10);

    // Readable drop on active source
    cur_sb = 12'h002; tick(10);
    cur_rd = 3'b110; tick(6);
    chk("rd_drop", 32'(bus.active_src), 0);
    cur_rd = 3'b111; cur_sb = 12'h000; tick(10);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) cur_sb[$urandom_range(11)] ^= 1'b1;
      if ($urandom_range(63) == 0) cur_rd = 3'($urandom);
      if ($urandom_range(63) == 0) cur_ch = 2'($urandom);
      if ($urandom_range(127) == 0) cur_ae = ~cur_ae;
      cur_rst = ($urandom_range(499) != 0);
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
